acc_ctrl_fsm: RTL and testbench
===============================

ACC_CTRL_FSM -- requirements
Module: acc_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter MSG_WORDS, default 16, giving the maximum message words per job.
REQ-002 The block SHALL have parameter DIG_WORDS, default 8, giving the digest words read back per job.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum WAIT_HASH cycles before an error.
REQ-004 The block SHALL expose these ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  job start pulse.
- abort_i  in  1  abort request.
- ack_i  in  1  software acknowledge of DONE.
- cfg_len_i  in  $clog2(MSG_WORDS+1)  message length in words.
- in_valid_i  in  1  message word valid.
- in_data_i  in  32  message word.
- in_ready_o  out  1  message word accepted.
- core_we_o  out  1  hash core write enable.
- core_waddr_o  out  $clog2(MSG_WORDS)  hash core write address.
- core_wdata_o  out  32  hash core write data.
- core_start_o  out  1  hash core start pulse.
- core_done_i  in  1  hash core finished.
- core_re_o  out  1  digest read enable.
- core_raddr_o  out  $clog2(DIG_WORDS)  digest read address.
- core_rdata_i  in  32  digest data, valid one cycle after core_re_o.
- out_valid_o  out  1  digest word valid.
- out_data_o  out  32  digest word.
- out_ready_i  in  1  consumer ready for the digest word.
- status_o  out  4  acc_state_t encoding from cfg_types_pkg.
- error_o  out  4  acc_error_t encoding from cfg_types_pkg.
- busy_o  out  1  high in any state other than ST_IDLE and ST_DONE.
- irq_o  out  1  completion interrupt pulse.

Function
REQ-005 The block SHALL implement a state register of type acc_state_t with states ST_IDLE, ST_WRITE, ST_WAIT_HASH, ST_READ and ST_DONE, and status_o SHALL equal that register.
REQ-006 ST_IDLE, start_i=1, cfg_len_i in 1..MSG_WORDS: the block SHALL go to ST_WRITE, clear the word, read and timeout counters, and set error_o=ER_OKAY.
REQ-007 ST_IDLE, start_i=1, cfg_len_i=0 or cfg_len_i>MSG_WORDS: the block SHALL go to ST_DONE with error_o=ER_INVALID_CFG and SHALL NOT assert any core_* output.
REQ-008 In ST_WRITE, in_ready_o SHALL be 1; in every other state in_ready_o SHALL be 0.
REQ-009 In ST_WRITE, core_we_o SHALL equal in_valid_i, core_wdata_o SHALL equal in_data_i, and core_waddr_o SHALL equal the word counter (all combinational).
REQ-010 Each accepted word (in_valid_i & in_ready_o) SHALL increment the word counter by 1.
REQ-011 When the word numbered cfg_len_i-1 is accepted, the block SHALL go to ST_WAIT_HASH, and core_start_o SHALL be a registered one-cycle pulse in the first ST_WAIT_HASH cycle.
REQ-012 In ST_WAIT_HASH, core_done_i=1 SHALL move the block to ST_READ.
REQ-013 In ST_WAIT_HASH, the timeout counter SHALL increment every cycle; when it reaches TIMEOUT-1 without core_done_i, the block SHALL go to ST_DONE with error_o=ER_OTHERS.
REQ-014 If core_done_i and the timeout are reached in the same cycle, core_done_i SHALL win.
REQ-015 In ST_READ, the block SHALL pulse core_re_o with core_raddr_o set to the read counter, and SHALL register core_rdata_i into out_data_o one cycle later with out_valid_o=1.
REQ-016 out_valid_o and out_data_o SHALL stay stable until out_ready_i=1.
REQ-017 The next core_re_o SHALL be issued no earlier than the cycle after the handshake, so at most one digest word is outstanding.
REQ-018 When the handshake for word DIG_WORDS-1 completes, the block SHALL go to ST_DONE with error_o unchanged (ER_OKAY).
REQ-019 On every entry to ST_DONE, whether by success, error or abort, irq_o SHALL pulse high for exactly one cycle.
REQ-020 In ST_DONE, ack_i SHALL return the block to ST_IDLE with error_o retained, and start_i SHALL be ignored.
REQ-021 In ST_WRITE, ST_WAIT_HASH or ST_READ, abort_i SHALL force ST_DONE with error_o=ER_OTHERS and SHALL drop out_valid_o in the following cycle.
REQ-022 abort_i SHALL take priority over every other event; in ST_IDLE and ST_DONE it SHALL have no effect.
REQ-023 start_i SHALL be ignored in every state other than ST_IDLE.

Reset
REQ-024 While rst_i is high, state SHALL be ST_IDLE and error_o SHALL be ER_OKAY.
REQ-025 While rst_i is high, all counters SHALL be 0, all *_o strobes and valids SHALL be 0, and out_data_o SHALL be 32'h0.
REQ-026 Reset asserted mid-job SHALL abandon the job immediately with no irq_o pulse.
REQ-027 After reset release, the block SHALL accept start_i on the first clk_i edge.

Verification
REQ-028 The bench SHALL run a nominal job: cfg_len_i=4, words 0xA0..0xA3 back-to-back, core_done_i after 10 cycles, out_ready_i=1 -> core_waddr_o 0..3, one core_start_o pulse, 8 digest words in address order, ST_DONE, a single irq_o pulse, error_o=ER_OKAY.
REQ-029 The bench SHALL check invalid lengths: cfg_len_i=0, and separately cfg_len_i=17 -> ST_DONE, error_o=ER_INVALID_CFG, no core_we_o, irq_o pulse.
REQ-030 The bench SHALL check timeout with TIMEOUT=16 and core_done_i never asserted -> ST_DONE exactly 16 cycles after entering ST_WAIT_HASH, error_o=ER_OTHERS.
REQ-031 The bench SHALL check backpressure: out_ready_i low for 5 cycles on digest word 2 -> out_data_o held stable, no extra core_re_o issued, all 8 words delivered.
REQ-032 The bench SHALL check abort_i in the cycle after the 2nd write -> ST_DONE with ER_OTHERS, in_ready_o=0; then ack_i -> ST_IDLE.
REQ-033 The bench SHALL check reset: rst_i asserted in ST_READ -> ST_IDLE, outputs 0, no irq_o pulse; a new job then completes normally.

Source files
------------

// File: rtl/acc_ctrl_fsm.sv
// Accelerator job controller: streams message words into a hash core, waits for
// completion, then reads the digest back one word at a time with flow control.
package cfg_types_pkg;
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WRITE     = 4'd1,
        ST_WAIT_HASH = 4'd2,
        ST_READ      = 4'd3,
        ST_DONE      = 4'd4
    } acc_state_t;

    typedef enum logic [3:0] {
        ER_OKAY        = 4'd0,
        ER_INVALID_CFG = 4'd1,
        ER_OTHERS      = 4'd2
    } acc_error_t;
endpackage

// state        | meaning
// ST_IDLE      | waiting for start_i
// ST_WRITE     | accepting message words into the core
// ST_WAIT_HASH | core running, timeout counter active
// ST_READ      | fetching digest words, one outstanding at most
// ST_DONE      | job finished, holding error_o until ack_i
module acc_ctrl_fsm
    import cfg_types_pkg::*;
#(
    parameter int MSG_WORDS = 16,
    parameter int DIG_WORDS = 8,
    parameter int TIMEOUT   = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic                             ack_i,
    input  logic [$clog2(MSG_WORDS+1)-1:0]   cfg_len_i,
    input  logic                             in_valid_i,
    input  logic [31:0]                      in_data_i,
    output logic                             in_ready_o,
    output logic                             core_we_o,
    output logic [$clog2(MSG_WORDS)-1:0]     core_waddr_o,
    output logic [31:0]                      core_wdata_o,
    output logic                             core_start_o,
    input  logic                             core_done_i,
    output logic                             core_re_o,
    output logic [$clog2(DIG_WORDS)-1:0]     core_raddr_o,
    input  logic [31:0]                      core_rdata_i,
    output logic                             out_valid_o,
    output logic [31:0]                      out_data_o,
    input  logic                             out_ready_i,
    output logic [3:0]                       status_o,
    output logic [3:0]                       error_o,
    output logic                             busy_o,
    output logic                             irq_o
);

    localparam int LEN_W   = $clog2(MSG_WORDS + 1);
    localparam int WADDR_W = $clog2(MSG_WORDS);
    localparam int RADDR_W = $clog2(DIG_WORDS);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MSG_WORDS);
    localparam logic [RADDR_W-1:0] RD_LAST  = RADDR_W'(DIG_WORDS - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);

    acc_state_t          state_q, state_d;
    acc_error_t          err_q, err_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    word_q, word_d;
    logic [RADDR_W-1:0]  rd_q, rd_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                rd_pend_q, rd_pend_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;
    logic                core_start_q, core_start_d;
    logic                irq_q, irq_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            err_q        <= ER_OKAY;
            len_q        <= '0;
            word_q       <= '0;
            rd_q         <= '0;
            tmo_q        <= '0;
            rd_pend_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h0;
            core_start_q <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            len_q        <= len_d;
            word_q       <= word_d;
            rd_q         <= rd_d;
            tmo_q        <= tmo_d;
            rd_pend_q    <= rd_pend_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            core_start_q <= core_start_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        len_d        = len_q;
        word_d       = word_q;
        rd_d         = rd_q;
        tmo_d        = tmo_q;
        rd_pend_d    = rd_pend_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        core_start_d = 1'b0;
        in_ready_o   = 1'b0;
        core_we_o    = 1'b0;
        core_waddr_o = '0;
        core_wdata_o = 32'h0;
        core_re_o    = 1'b0;
        core_raddr_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfg_len_i != '0 && cfg_len_i <= LEN_MAX) begin
                        state_d = ST_WRITE;
                        err_d   = ER_OKAY;
                        len_d   = cfg_len_i;
                        word_d  = '0;
                        rd_d    = '0;
                        tmo_d   = '0;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = ER_INVALID_CFG;
                    end
                end
            end
            ST_WRITE: begin
                in_ready_o   = 1'b1;
                core_we_o    = in_valid_i;
                core_waddr_o = word_q[WADDR_W-1:0];
                core_wdata_o = in_data_i;
                if (in_valid_i) begin
                    word_d = word_q + LEN_W'(1);
                    if (word_q == len_q - LEN_W'(1)) begin
                        state_d      = ST_WAIT_HASH;
                        core_start_d = 1'b1;
                    end
                end
            end
            ST_WAIT_HASH: begin
                tmo_d = tmo_q + TMO_W'(1);
                // done beats a timeout landing in the same cycle
                if (core_done_i) begin
                    state_d = ST_READ;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_DONE;
                    err_d   = ER_OTHERS;
                end
            end
            ST_READ: begin
                if (rd_pend_q) begin
                    out_data_d  = core_rdata_i;
                    out_valid_d = 1'b1;
                    rd_pend_d   = 1'b0;
                end else if (out_valid_q) begin
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        if (rd_q == RD_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            rd_d = rd_q + RADDR_W'(1);
                        end
                    end
                end else begin
                    core_re_o    = 1'b1;
                    core_raddr_o = rd_q;
                    rd_pend_d    = 1'b1;
                end
            end
            ST_DONE: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_i && (state_q inside {ST_WRITE, ST_WAIT_HASH, ST_READ})) begin
            state_d      = ST_DONE;
            err_d        = ER_OTHERS;
            out_valid_d  = 1'b0;
            rd_pend_d    = 1'b0;
            core_start_d = 1'b0;
        end

        irq_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    assign core_start_o = core_start_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign irq_o        = irq_q;
    assign status_o     = state_q;
    assign error_o      = err_q;
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_acc_ctrl_fsm.sv
// Directed bench for acc_ctrl_fsm: nominal job, bad lengths, timeout, digest
// backpressure, abort and mid-job reset, against hand-computed expectations.
module tb_acc_ctrl_fsm;
    import cfg_types_pkg::*;

    localparam int MSG_WORDS = 16;
    localparam int DIG_WORDS = 8;
    localparam int TIMEOUT   = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, abort_i, ack_i;
    logic [4:0]  cfg_len_i;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        core_we_o;
    logic [3:0]  core_waddr_o;
    logic [31:0] core_wdata_o;
    logic        core_start_o;
    logic        core_done_i;
    logic        core_re_o;
    logic [2:0]  core_raddr_o;
    logic [31:0] core_rdata_i;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_ready_i;
    logic [3:0]  status_o, error_o;
    logic        busy_o, irq_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] we_addr_q[$];
    logic [31:0] we_data_q[$];
    logic [31:0] re_addr_q[$];
    logic [31:0] dig_q[$];
    int start_cnt = 0;
    int irq_cnt   = 0;
    int done_delay = 0;
    int done_timer = 0;

    acc_ctrl_fsm #(
        .MSG_WORDS(MSG_WORDS),
        .DIG_WORDS(DIG_WORDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .ack_i       (ack_i),
        .cfg_len_i   (cfg_len_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .core_we_o   (core_we_o),
        .core_waddr_o(core_waddr_o),
        .core_wdata_o(core_wdata_o),
        .core_start_o(core_start_o),
        .core_done_i (core_done_i),
        .core_re_o   (core_re_o),
        .core_raddr_o(core_raddr_o),
        .core_rdata_i(core_rdata_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .status_o    (status_o),
        .error_o     (error_o),
        .busy_o      (busy_o),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Hash core model and event logging, all sampled mid-cycle.
    always @(negedge clk_i) begin
        if (core_done_i) core_done_i = 1'b0;
        if (rst_i) begin
            done_timer = 0;
        end else if (core_start_o && done_delay > 0) begin
            done_timer = done_delay;
        end else if (done_timer > 0) begin
            done_timer = done_timer - 1;
            if (done_timer == 0) core_done_i = 1'b1;
        end
        if (core_we_o) begin
            we_addr_q.push_back(32'(core_waddr_o));
            we_data_q.push_back(core_wdata_o);
        end
        if (core_re_o) begin
            re_addr_q.push_back(32'(core_raddr_o));
            core_rdata_i = 32'hD000_0000 | 32'(core_raddr_o);
        end
        if (out_valid_o && out_ready_i) dig_q.push_back(out_data_o);
        if (core_start_o) start_cnt = start_cnt + 1;
        if (irq_o) irq_cnt = irq_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_state(input acc_state_t target, input int budget, input string tag);
        int n = 0;
        while (status_o != 4'(target) && n < budget) begin
            step();
            n++;
        end
        check_val(tag, 32'(status_o), 32'(target));
    endtask

    task automatic do_ack(input acc_error_t exp_err, input string tag);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check_val({tag, "_ack_idle"}, 32'(status_o), 32'(ST_IDLE));
        check_val({tag, "_ack_err_kept"}, 32'(error_o), 32'(exp_err));
    endtask

    task automatic run_job(input int len, input int dly, input bit rel, input bit hold, input string tag);
        int base_we = we_addr_q.size();
        int base_re = re_addr_q.size();
        int base_dg = dig_q.size();
        int base_st = start_cnt;
        int base_irq = irq_cnt;
        int n = 0;
        bit held = 1'b0;
        int idx;
        logic [31:0] got;
        logic [31:0] hold_data;
        int hold_re;
        done_delay = dly;
        out_ready_i = 1'b1;
        cfg_len_i = 5'(len);
        start_i = 1'b1;
        if (rel) rst_i = 1'b0;
        step();
        start_i = 1'b0;
        check_val({tag, "_write"}, 32'(status_o), 32'(ST_WRITE));
        check_val({tag, "_in_ready_write"}, 32'(in_ready_o), 32'd1);
        for (int i = 0; i < len; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 32'hA0 + 32'(i);
            step();
        end
        in_valid_i = 1'b0;
        check_val({tag, "_wait_hash"}, 32'(status_o), 32'(ST_WAIT_HASH));
        check_val({tag, "_in_ready_wait"}, 32'(in_ready_o), 32'd0);
        while (status_o != 4'(ST_DONE) && n < 300) begin
            if (hold && !held && out_valid_o && out_data_o == 32'hD000_0002) begin
                held = 1'b1;
                out_ready_i = 1'b0;
                hold_data = out_data_o;
                hold_re = re_addr_q.size();
                for (int k = 0; k < 5; k++) begin
                    step();
                    check_val({tag, "_hold_valid"}, 32'(out_valid_o), 32'd1);
                    check_val({tag, "_hold_data"}, out_data_o, hold_data);
                end
                check_val({tag, "_hold_no_re"}, 32'(re_addr_q.size()), 32'(hold_re));
                out_ready_i = 1'b1;
            end else begin
                step();
                n++;
            end
        end
        check_val({tag, "_done"}, 32'(status_o), 32'(ST_DONE));
        if (hold) check_val({tag, "_hold_seen"}, 32'(held), 32'd1);
        step();
        check_val({tag, "_we_count"}, 32'(we_addr_q.size() - base_we), 32'(len));
        for (int i = 0; i < len; i++) begin
            idx = base_we + i;
            got = (idx < we_addr_q.size()) ? we_addr_q[idx] : 32'hFFFF_FFFF;
            check_val({tag, "_waddr"}, got, 32'(i));
            got = (idx < we_data_q.size()) ? we_data_q[idx] : 32'hFFFF_FFFF;
            check_val({tag, "_wdata"}, got, 32'hA0 + 32'(i));
        end
        check_val({tag, "_start_pulses"}, 32'(start_cnt - base_st), 32'd1);
        check_val({tag, "_re_count"}, 32'(re_addr_q.size() - base_re), 32'(DIG_WORDS));
        check_val({tag, "_dig_count"}, 32'(dig_q.size() - base_dg), 32'(DIG_WORDS));
        for (int i = 0; i < DIG_WORDS; i++) begin
            idx = base_re + i;
            got = (idx < re_addr_q.size()) ? re_addr_q[idx] : 32'hFFFF_FFFF;
            check_val({tag, "_raddr"}, got, 32'(i));
            idx = base_dg + i;
            got = (idx < dig_q.size()) ? dig_q[idx] : 32'hFFFF_FFFF;
            check_val({tag, "_digest"}, got, 32'hD000_0000 + 32'(i));
        end
        check_val({tag, "_irq_once"}, 32'(irq_cnt - base_irq), 32'd1);
        check_val({tag, "_err_okay"}, 32'(error_o), 32'(ER_OKAY));
        check_val({tag, "_busy_done"}, 32'(busy_o), 32'd0);
    endtask

    task automatic bad_len(input int len, input string tag);
        int base_we = we_addr_q.size();
        int base_st = start_cnt;
        int base_irq = irq_cnt;
        cfg_len_i = 5'(len);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_val({tag, "_state"}, 32'(status_o), 32'(ST_DONE));
        check_val({tag, "_err"}, 32'(error_o), 32'(ER_INVALID_CFG));
        step();
        check_val({tag, "_irq"}, 32'(irq_cnt - base_irq), 32'd1);
        check_val({tag, "_no_we"}, 32'(we_addr_q.size() - base_we), 32'd0);
        check_val({tag, "_no_start"}, 32'(start_cnt - base_st), 32'd0);
        do_ack(ER_INVALID_CFG, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int base_irq;
        int base_we;
        int base_st;
        rst_i = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        ack_i = 1'b0;
        cfg_len_i = '0;
        in_valid_i = 1'b0;
        in_data_i = '0;
        core_done_i = 1'b0;
        core_rdata_i = '0;
        out_ready_i = 1'b1;
        repeat (3) step();
        check_val("rst_state", 32'(status_o), 32'(ST_IDLE));
        check_val("rst_err", 32'(error_o), 32'(ER_OKAY));
        check_val("rst_outs", {26'd0, in_ready_o, core_we_o, core_start_o, core_re_o, out_valid_o, irq_o}, 32'd0);
        check_val("rst_out_data", out_data_o, 32'h0);
        check_val("rst_busy", 32'(busy_o), 32'd0);

        // start on the very edge that follows reset release
        run_job(4, 10, 1'b1, 1'b0, "nominal");
        cfg_len_i = 5'd4;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check_val("done_ignores_start", 32'(status_o), 32'(ST_DONE));
        do_ack(ER_OKAY, "nominal");

        bad_len(0, "len0");
        bad_len(17, "len17");

        done_delay = 0;
        base_irq = irq_cnt;
        cfg_len_i = 5'd1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        in_data_i = 32'h55;
        step();
        in_valid_i = 1'b0;
        check_val("tmo_wait", 32'(status_o), 32'(ST_WAIT_HASH));
        n = 0;
        while (status_o != 4'(ST_DONE) && n < 100) begin
            step();
            n++;
        end
        check_val("tmo_cycles", 32'(n), 32'd16);
        check_val("tmo_err", 32'(error_o), 32'(ER_OTHERS));
        step();
        check_val("tmo_irq", 32'(irq_cnt - base_irq), 32'd1);
        do_ack(ER_OTHERS, "tmo");

        run_job(2, 3, 1'b0, 1'b1, "bp");
        do_ack(ER_OKAY, "bp");

        base_irq = irq_cnt;
        base_we = we_addr_q.size();
        base_st = start_cnt;
        cfg_len_i = 5'd4;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1;
            in_data_i = 32'hB0 + 32'(i);
            step();
        end
        in_valid_i = 1'b0;
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_val("abort_state", 32'(status_o), 32'(ST_DONE));
        check_val("abort_err", 32'(error_o), 32'(ER_OTHERS));
        check_val("abort_in_ready", 32'(in_ready_o), 32'd0);
        step();
        check_val("abort_irq", 32'(irq_cnt - base_irq), 32'd1);
        check_val("abort_we", 32'(we_addr_q.size() - base_we), 32'd2);
        check_val("abort_no_start", 32'(start_cnt - base_st), 32'd0);
        do_ack(ER_OTHERS, "abort");

        done_delay = 2;
        out_ready_i = 1'b0;
        cfg_len_i = 5'd1;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        in_valid_i = 1'b1;
        in_data_i = 32'hC0;
        step();
        in_valid_i = 1'b0;
        wait_state(ST_READ, 50, "rstjob_read");
        repeat (3) step();
        check_val("rstjob_valid_before", 32'(out_valid_o), 32'd1);
        base_irq = irq_cnt;
        rst_i = 1'b1;
        #1;
        check_val("rstjob_state", 32'(status_o), 32'(ST_IDLE));
        check_val("rstjob_err", 32'(error_o), 32'(ER_OKAY));
        check_val("rstjob_outs", {26'd0, in_ready_o, core_we_o, core_start_o, core_re_o, out_valid_o, irq_o}, 32'd0);
        check_val("rstjob_out_data", out_data_o, 32'h0);
        repeat (2) step();
        check_val("rstjob_no_irq", 32'(irq_cnt - base_irq), 32'd0);
        run_job(4, 10, 1'b1, 1'b0, "after_rst");
        do_ack(ER_OKAY, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
